// File: rtl/dram_rr_arbiter.sv
// dram_rr_arbiter
// Shares one single-port data RAM (registered 1-cycle read) between
// N_CORES core requesters and one external loader/debug port. The external
// port always wins; cores are served round-robin starting after the last
// core granted. All memory strobes, address/data and acknowledges are
// registered; read data is passed straight through from the RAM.
//
// Ports
//   clock, reset_n               system clock, synchronous active-low reset
//   core_req/we/addr/wdata       per-core request (packed, core i at i*W)
//   core_ack, core_rdata         per-core completion pulse, shared read data
//   ext_req/we/addr/wdata        external port request
//   ext_ack, ext_rdata           external completion pulse and read data
//   mem_write_en, mem_read_en    RAM strobes
//   mem_addr, mem_data_in        RAM address and write data
//   mem_data_out                 RAM read data (one cycle after mem_read_en)
//   busy                         high whenever an access is in flight
//
// state  | meaning
// IDLE   | arbitrate; latch winner into mem_* registers
// ACCESS | strobes on the RAM; write ack pulses here
// RDATA  | RAM data valid; read ack pulses here
module dram_rr_arbiter #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [N_CORES-1:0]          core_req,
  input  logic [N_CORES-1:0]          core_we,
  input  logic [N_CORES*ADDR_W-1:0]   core_addr,
  input  logic [N_CORES*DATA_W-1:0]   core_wdata,
  output logic [N_CORES-1:0]          core_ack,
  output logic [DATA_W-1:0]           core_rdata,
  input  logic                        ext_req,
  input  logic                        ext_we,
  input  logic [ADDR_W-1:0]           ext_addr,
  input  logic [DATA_W-1:0]           ext_wdata,
  output logic                        ext_ack,
  output logic [DATA_W-1:0]           ext_rdata,
  output logic                        mem_write_en,
  output logic                        mem_read_en,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_data_in,
  input  logic [DATA_W-1:0]           mem_data_out,
  output logic                        busy
);

  localparam int PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     win_q, win_d;
  logic                 ext_sel_q, ext_sel_d;
  logic                 mem_we_q, mem_we_d;
  logic                 mem_re_q, mem_re_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    din_q, din_d;
  logic [N_CORES-1:0]   core_ack_q, core_ack_d;
  logic                 ext_ack_q, ext_ack_d;
  logic                 found;
  logic [PTR_W-1:0]     cand;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    ext_sel_d  = ext_sel_q;
    mem_we_d   = 1'b0;
    mem_re_d   = 1'b0;
    addr_d     = addr_q;
    din_d      = din_q;
    core_ack_d = '0;
    ext_ack_d  = 1'b0;
    found      = 1'b0;
    cand       = '0;
    case (state_q)
      IDLE: begin
        if (ext_req) begin
          ext_sel_d = 1'b1;
          mem_we_d  = ext_we;
          mem_re_d  = !ext_we;
          addr_d    = ext_addr;
          din_d     = ext_wdata;
          // write ack is registered to coincide with the ACCESS cycle
          ext_ack_d = ext_we;
          state_d   = ACCESS;
        end else begin
          // search ptr+1, ptr+2, ... so the last winner is considered last
          for (int k = 1; k <= N_CORES; k++) begin
            cand = PTR_W'((int'(ptr_q) + k) % N_CORES);
            if (!found && core_req[cand]) begin
              found = 1'b1;
              win_d = cand;
            end
          end
          if (found) begin
            ext_sel_d         = 1'b0;
            ptr_d             = win_d;
            mem_we_d          = core_we[win_d];
            mem_re_d          = !core_we[win_d];
            addr_d            = core_addr[win_d*ADDR_W +: ADDR_W];
            din_d             = core_wdata[win_d*DATA_W +: DATA_W];
            core_ack_d[win_d] = core_we[win_d];
            state_d           = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (mem_we_q) begin
          state_d = IDLE;
        end else begin
          state_d = RDATA;
          if (ext_sel_q) ext_ack_d = 1'b1;
          else           core_ack_d[win_q] = 1'b1;
        end
      end
      RDATA:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= PTR_W'(N_CORES - 1);
      win_q      <= '0;
      ext_sel_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_re_q   <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      core_ack_q <= '0;
      ext_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      ext_sel_q  <= ext_sel_d;
      mem_we_q   <= mem_we_d;
      mem_re_q   <= mem_re_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      core_ack_q <= core_ack_d;
      ext_ack_q  <= ext_ack_d;
    end
  end

  assign mem_write_en = mem_we_q;
  assign mem_read_en  = mem_re_q;
  assign mem_addr     = addr_q;
  assign mem_data_in  = din_q;
  assign core_ack     = core_ack_q;
  assign ext_ack      = ext_ack_q;
  assign core_rdata   = mem_data_out;
  assign ext_rdata    = mem_data_out;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_dram_rr_arbiter.sv
// Bench for dram_rr_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model (grant time, rotating priority, shadow RAM).
module tb_dram_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 9;
  localparam int DW = 16;
  localparam int NC = 1200;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0]    core_req, core_we, core_ack;
  logic [N*AW-1:0] core_addr;
  logic [N*DW-1:0] core_wdata;
  logic [DW-1:0]   core_rdata, ext_rdata, ext_wdata, mem_data_in, mem_data_out;
  logic            ext_req, ext_we, ext_ack, mem_write_en, mem_read_en, busy;
  logic [AW-1:0]   ext_addr, mem_addr;

  int n_checks = 0;
  int n_pass = 0;

  logic [DW-1:0] ram [0:511];
  logic          ram_loaded = 1'b0;

  logic [N-1:0]  e_cack [0:NC+3];
  logic          e_eack [0:NC+3];
  logic          e_busy [0:NC+3];
  logic          e_rchk [0:NC+3];
  logic [DW-1:0] e_rd   [0:NC+3];
  logic [DW-1:0] shadow [0:511];

  always #5 clock = ~clock;

  dram_rr_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset_n(reset_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ack(core_ack), .core_rdata(core_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ack(ext_ack), .ext_rdata(ext_rdata),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
  );

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'((a * 37) ^ 16'h5A00);
  endfunction

  // single-port RAM with registered read
  always @(posedge clock) begin
    if (!ram_loaded) begin
      for (int a = 0; a < 512; a++) ram[a] <= init_val(a);
      ram_loaded <= 1'b1;
    end else begin
      if (mem_write_en) ram[mem_addr] <= mem_data_in;
      if (mem_read_en) mem_data_out <= ram[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
  endtask

  task automatic set_core(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    core_req[i] = 1'b1;
    core_we[i] = we;
    core_addr[i*AW +: AW] = a;
    core_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    n_checks++; if (core_ack !== 4'b0000) $display("FAIL rst_core_ack got %b exp 0000", core_ack); else n_pass++;
    n_checks++; if (ext_ack !== 1'b0) $display("FAIL rst_ext_ack got %b exp 0", ext_ack); else n_pass++;
    n_checks++; if (mem_write_en !== 1'b0) $display("FAIL rst_mem_we got %b exp 0", mem_write_en); else n_pass++;
    n_checks++; if (mem_read_en !== 1'b0) $display("FAIL rst_mem_re got %b exp 0", mem_read_en); else n_pass++;
    n_checks++; if (mem_addr !== 9'h000) $display("FAIL rst_mem_addr got %h exp 000", mem_addr); else n_pass++;
    n_checks++; if (mem_data_in !== 16'h0000) $display("FAIL rst_mem_din got %h exp 0000", mem_data_in); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else n_pass++;
    reset_n = 1'b1;
  endtask

  task automatic test_write_read();
    set_core(2, 1'b1, 9'h005, 16'hBEEF);
    tick();
    n_checks++; if (core_ack !== 4'b0100) $display("FAIL wr_ack got %b exp 0100", core_ack); else n_pass++;
    n_checks++; if (mem_write_en !== 1'b1 || mem_read_en !== 1'b0) $display("FAIL wr_strobes got we=%b re=%b exp we=1 re=0", mem_write_en, mem_read_en); else n_pass++;
    n_checks++; if (mem_addr !== 9'h005 || mem_data_in !== 16'hBEEF) $display("FAIL wr_addr_data got %h/%h exp 005/beef", mem_addr, mem_data_in); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL wr_busy got %b exp 1", busy); else n_pass++;
    set_core(2, 1'b0, 9'h005, 16'h0000);
    tick();
    n_checks++; if (core_ack !== 4'b0000 || busy !== 1'b0) $display("FAIL wr_idle got ack=%b busy=%b exp 0000/0", core_ack, busy); else n_pass++;
    n_checks++; if (ram[5] !== 16'hBEEF) $display("FAIL wr_ram got %h exp beef", ram[5]); else n_pass++;
    tick();
    n_checks++; if (mem_read_en !== 1'b1 || core_ack !== 4'b0000) $display("FAIL rd_access got re=%b ack=%b exp 1/0000", mem_read_en, core_ack); else n_pass++;
    core_req[2] = 1'b0;
    tick();
    n_checks++; if (core_ack !== 4'b0100) $display("FAIL rd_ack got %b exp 0100", core_ack); else n_pass++;
    n_checks++; if (core_rdata !== 16'hBEEF) $display("FAIL rd_data got %h exp beef", core_rdata); else n_pass++;
    n_checks++; if (mem_read_en !== 1'b0) $display("FAIL rd_re_one_cycle got %b exp 0", mem_read_en); else n_pass++;
    tick();
    n_checks++; if (core_ack !== 4'b0000 || busy !== 1'b0) $display("FAIL rd_done got ack=%b busy=%b exp 0000/0", core_ack, busy); else n_pass++;
  endtask

  task automatic test_round_robin();
    clear_inputs();
    do_reset();
    for (int i = 0; i < N; i++) set_core(i, 1'b0, AW'(9'h020 + i), 16'h0000);
    for (int c = 1; c <= 17; c++) begin
      int k;
      logic [N-1:0] exp;
      tick();
      k = (c / 3) % 4;
      exp = (c % 3 == 2) ? 4'(1 << k) : 4'b0000;
      n_checks++; if (core_ack !== exp) $display("FAIL rr_ack cycle %0d got %b exp %b", c, core_ack, exp); else n_pass++;
      if (exp != 4'b0000) begin
        n_checks++; if (core_rdata !== init_val(32 + k)) $display("FAIL rr_data cycle %0d got %h exp %h", c, core_rdata, init_val(32 + k)); else n_pass++;
      end
    end
    clear_inputs();
    tick();
    n_checks++; if (core_ack !== 4'b0000 || busy !== 1'b0) $display("FAIL rr_end got ack=%b busy=%b exp 0000/0", core_ack, busy); else n_pass++;
  endtask

  task automatic test_ext_priority();
    clear_inputs();
    do_reset();
    set_core(0, 1'b0, 9'h030, 16'h0000);
    set_core(1, 1'b0, 9'h031, 16'h0000);
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 9'h1FF; ext_wdata = 16'h1234;
    tick();
    n_checks++; if (ext_ack !== 1'b1 || core_ack !== 4'b0000) $display("FAIL ext_ack got ext=%b core=%b exp 1/0000", ext_ack, core_ack); else n_pass++;
    n_checks++; if (mem_write_en !== 1'b1 || mem_addr !== 9'h1FF || mem_data_in !== 16'h1234) $display("FAIL ext_mem got we=%b %h/%h exp 1 1ff/1234", mem_write_en, mem_addr, mem_data_in); else n_pass++;
    ext_req = 1'b0;
    tick();
    n_checks++; if (ram[511] !== 16'h1234 || ext_ack !== 1'b0) $display("FAIL ext_ram got %h ack=%b exp 1234/0", ram[511], ext_ack); else n_pass++;
    tick();
    n_checks++; if (mem_read_en !== 1'b1 || mem_addr !== 9'h030) $display("FAIL ext_next_grant got re=%b addr=%h exp 1/030", mem_read_en, mem_addr); else n_pass++;
    tick();
    n_checks++; if (core_ack !== 4'b0001 || core_rdata !== init_val(48)) $display("FAIL ext_core0 got %b/%h exp 0001/%h", core_ack, core_rdata, init_val(48)); else n_pass++;
    core_req[0] = 1'b0;
    tick();
    tick();
    tick();
    n_checks++; if (core_ack !== 4'b0010 || core_rdata !== init_val(49)) $display("FAIL ext_core1 got %b/%h exp 0010/%h", core_ack, core_rdata, init_val(49)); else n_pass++;
    core_req[1] = 1'b0;
    tick();
  endtask

  task automatic test_fairness_skip();
    set_core(1, 1'b0, 9'h041, 16'h0000);
    set_core(3, 1'b0, 9'h043, 16'h0000);
    tick();
    n_checks++; if (mem_addr !== 9'h043) $display("FAIL skip_first_addr got %h exp 043", mem_addr); else n_pass++;
    tick();
    n_checks++; if (core_ack !== 4'b1000 || core_rdata !== init_val(67)) $display("FAIL skip_core3 got %b/%h exp 1000/%h", core_ack, core_rdata, init_val(67)); else n_pass++;
    core_req[3] = 1'b0;
    tick();
    tick();
    tick();
    n_checks++; if (core_ack !== 4'b0010 || core_rdata !== init_val(65)) $display("FAIL skip_core1 got %b/%h exp 0010/%h", core_ack, core_rdata, init_val(65)); else n_pass++;
    core_req[1] = 1'b0;
    tick();
    set_core(0, 1'b1, 9'h050, 16'h0A0A);
    set_core(2, 1'b1, 9'h052, 16'h2B2B);
    tick();
    n_checks++; if (core_ack !== 4'b0100 || mem_addr !== 9'h052) $display("FAIL skip_ptr got ack=%b addr=%h exp 0100/052", core_ack, mem_addr); else n_pass++;
    core_req[2] = 1'b0;
    tick();
    tick();
    n_checks++; if (core_ack !== 4'b0001 || mem_addr !== 9'h050) $display("FAIL skip_core0 got ack=%b addr=%h exp 0001/050", core_ack, mem_addr); else n_pass++;
    core_req[0] = 1'b0;
    tick();
    n_checks++; if (ram[82] !== 16'h2B2B || ram[80] !== 16'h0A0A) $display("FAIL skip_ram got %h/%h exp 2b2b/0a0a", ram[82], ram[80]); else n_pass++;
  endtask

  task automatic test_dropped();
    set_core(0, 1'b1, 9'h010, 16'hCAFE);
    tick();
    n_checks++; if (core_ack !== 4'b0001) $display("FAIL drop_wr_ack got %b exp 0001", core_ack); else n_pass++;
    core_req[0] = 1'b0;
    tick();
    n_checks++; if (core_ack !== 4'b0000 || ram[16] !== 16'hCAFE) $display("FAIL drop_wr_ram got ack=%b ram=%h exp 0000/cafe", core_ack, ram[16]); else n_pass++;
    tick();
    n_checks++; if (core_ack !== 4'b0000 || busy !== 1'b0 || mem_write_en !== 1'b0) $display("FAIL drop_wr_repeat got ack=%b busy=%b we=%b exp 0000/0/0", core_ack, busy, mem_write_en); else n_pass++;
    set_core(0, 1'b0, 9'h010, 16'h0000);
    tick();
    core_req[0] = 1'b0;
    n_checks++; if (mem_read_en !== 1'b1) $display("FAIL drop_rd_re got %b exp 1", mem_read_en); else n_pass++;
    tick();
    n_checks++; if (core_ack !== 4'b0001 || core_rdata !== 16'hCAFE) $display("FAIL drop_rd_ack got %b/%h exp 0001/cafe", core_ack, core_rdata); else n_pass++;
    tick();
    tick();
    n_checks++; if (core_ack !== 4'b0000 || busy !== 1'b0) $display("FAIL drop_rd_repeat got ack=%b busy=%b exp 0000/0", core_ack, busy); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    set_core(3, 1'b0, 9'h023, 16'h0000);
    tick();
    n_checks++; if (mem_read_en !== 1'b1) $display("FAIL rmr_access got %b exp 1", mem_read_en); else n_pass++;
    reset_n = 1'b0;
    set_core(0, 1'b0, 9'h021, 16'h0000);
    tick();
    n_checks++; if (core_ack !== 4'b0000 || ext_ack !== 1'b0 || busy !== 1'b0) $display("FAIL rmr_acks got core=%b ext=%b busy=%b exp 0000/0/0", core_ack, ext_ack, busy); else n_pass++;
    n_checks++; if (mem_read_en !== 1'b0 || mem_write_en !== 1'b0 || mem_addr !== 9'h000 || mem_data_in !== 16'h0000) $display("FAIL rmr_mem got re=%b we=%b %h/%h exp 0 0 000/0000", mem_read_en, mem_write_en, mem_addr, mem_data_in); else n_pass++;
    reset_n = 1'b1;
    tick();
    n_checks++; if (core_ack !== 4'b0000 || mem_addr !== 9'h021 || mem_read_en !== 1'b1) $display("FAIL rmr_first_grant got ack=%b addr=%h re=%b exp 0000/021/1", core_ack, mem_addr, mem_read_en); else n_pass++;
    tick();
    n_checks++; if (core_ack !== 4'b0001 || core_rdata !== init_val(33)) $display("FAIL rmr_core0 got %b/%h exp 0001/%h", core_ack, core_rdata, init_val(33)); else n_pass++;
    core_req[0] = 1'b0;
    tick();
    tick();
    tick();
    n_checks++; if (core_ack !== 4'b1000 || core_rdata !== init_val(35)) $display("FAIL rmr_core3 got %b/%h exp 1000/%h", core_ack, core_rdata, init_val(35)); else n_pass++;
    clear_inputs();
    tick();
  endtask

  // Transaction-level model: when the port is free, ext wins, else the first
  // requesting core after the last core winner. A write completes one cycle
  // after its grant and frees the port a cycle later; a read completes two
  // cycles after grant and frees the port a cycle later.
  task automatic test_random();
    int next_free;
    int m_ptr;
    int who;
    int idx;
    logic w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i <= NC + 3; i++) begin
      e_cack[i] = '0; e_eack[i] = 1'b0; e_busy[i] = 1'b0; e_rchk[i] = 1'b0; e_rd[i] = '0;
    end
    for (int i = 0; i < 512; i++) shadow[i] = init_val(i);
    clear_inputs();
    do_reset();
    next_free = 0;
    m_ptr = N - 1;
    for (int c = 0; c < NC; c++) begin
      if (c > 0) begin
        for (int i = 0; i < N; i++) if (e_cack[c-1][i]) core_req[i] = 1'b0;
        if (e_eack[c-1]) ext_req = 1'b0;
      end
      if (c < NC - 20) begin
        for (int i = 0; i < N; i++)
          if (!core_req[i] && $urandom_range(0, 99) < 35)
            set_core(i, 1'($urandom_range(0, 1)), AW'(9'h080 + $urandom_range(0, 15)), DW'($urandom));
        if (!ext_req && $urandom_range(0, 99) < 4) begin
          ext_req = 1'b1;
          ext_we = 1'($urandom_range(0, 1));
          ext_addr = AW'(9'h090 + $urandom_range(0, 15));
          ext_wdata = DW'($urandom);
        end
      end
      n_checks++; if (core_ack !== e_cack[c]) $display("FAIL rnd_core_ack cycle %0d got %b exp %b", c, core_ack, e_cack[c]); else n_pass++;
      n_checks++; if (ext_ack !== e_eack[c]) $display("FAIL rnd_ext_ack cycle %0d got %b exp %b", c, ext_ack, e_eack[c]); else n_pass++;
      n_checks++; if (busy !== e_busy[c]) $display("FAIL rnd_busy cycle %0d got %b exp %b", c, busy, e_busy[c]); else n_pass++;
      if (e_rchk[c]) begin
        n_checks++; if (core_rdata !== e_rd[c] || ext_rdata !== e_rd[c]) $display("FAIL rnd_rdata cycle %0d got %h/%h exp %h", c, core_rdata, ext_rdata, e_rd[c]); else n_pass++;
      end
      if (c == next_free) begin
        who = -2;
        if (ext_req) who = -1;
        else
          for (int k = 1; k <= N; k++) begin
            idx = (m_ptr + k) % N;
            if (who == -2 && core_req[idx]) who = idx;
          end
        if (who == -2) next_free = c + 1;
        else begin
          if (who == -1) begin
            w = ext_we; a = ext_addr; d = ext_wdata;
          end else begin
            w = core_we[who]; a = core_addr[who*AW +: AW]; d = core_wdata[who*DW +: DW];
            m_ptr = who;
          end
          e_busy[c+1] = 1'b1;
          if (w) begin
            shadow[a] = d;
            if (who == -1) e_eack[c+1] = 1'b1; else e_cack[c+1][who] = 1'b1;
            next_free = c + 2;
          end else begin
            e_busy[c+2] = 1'b1;
            e_rchk[c+2] = 1'b1;
            e_rd[c+2] = shadow[a];
            if (who == -1) e_eack[c+2] = 1'b1; else e_cack[c+2][who] = 1'b1;
            next_free = c + 3;
          end
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_write_read();
    test_round_robin();
    test_ext_priority();
    test_fairness_skip();
    test_dropped();
    test_reset_mid_read();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dram_rr_arbiter.md
# dram_rr_arbiter

Round-robin arbiter that shares one single-port data memory (1-cycle registered read latency, 9-bit address, 16-bit data) between N processor cores plus one external loader/debug port. It sits between the cores' memory-request signals and the shared data RAM, replacing per-core memory ports. All memory-side controls and acknowledges are registered. The external port has absolute priority for program/data preload and readback.

## Interface
- N_CORES, default 4: number of core requesters (2..8).
- ADDR_W, default 9: memory address width.
- DATA_W, default 16: data width.

- clock  in  1  system clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- core_req  in  N_CORES  per-core access request, level; held until matching core_ack.
- core_we  in  N_CORES  1 = write, 0 = read; valid while core_req high.
- core_addr  in  N_CORES*ADDR_W  packed addresses, core i at [i*ADDR_W +: ADDR_W].
- core_wdata  in  N_CORES*DATA_W  packed write data, same packing.
- core_ack  out  N_CORES  one-cycle pulse: write committed / read data valid.
- core_rdata  out  DATA_W  read data, shared; valid for core i only when core_ack[i]=1.
- ext_req, ext_we  in  1 each  external port request / write select.
- ext_addr  in  ADDR_W; ext_wdata  in  DATA_W.
- ext_ack  out  1  one-cycle completion pulse; ext_rdata  out  DATA_W.
- mem_write_en, mem_read_en  out  1 each  memory strobes, registered.
- mem_addr  out  ADDR_W; mem_data_in  out  DATA_W  registered.
- mem_data_out  in  DATA_W  memory read data, valid one cycle after mem_read_en.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, ACCESS, RDATA.
- IDLE: if ext_req=1, ext wins. Else if any core_req, winner = first requesting index searching ptr+1, ptr+2, … modulo N_CORES. Winner's we/addr/wdata latched into mem_* registers; mem_write_en=we, mem_read_en=~we; go ACCESS. No request: stay IDLE, strobes 0.
- ACCESS: strobes active this cycle, then cleared. Write: ack for winner asserted this cycle; next state IDLE. Read: no ack; next state RDATA.
- RDATA: ack for winner asserted; core_rdata/ext_rdata = mem_data_out (combinational pass-through); next IDLE.
- ptr updated to winning core index on each core grant only; ext grants leave ptr unchanged.
- Requester inputs sampled only in IDLE; a request dropped after grant still completes (access performed, ack pulsed).
- At most one bit of {core_ack, ext_ack} high in any cycle.
- Address/data are passed unmodified; no width arithmetic beyond index*width slicing.

## Timing
- Reset (reset_n=0 at an edge): state IDLE, ptr=N_CORES-1 (core 0 served first), mem_write_en=mem_read_en=0, mem_addr=0, mem_data_in=0, all acks 0, busy=0. Strobes/acks already registered for the current cycle complete; nothing issued after.
- Request seen in IDLE at cycle T: strobes and mem_addr at T+1.
- Write: ack at T+1; 2 cycles per write; next arbitration at T+2.
- Read: ack and valid rdata at T+2; 3 cycles per read; next arbitration at T+3.
- Requester must present its next request (or drop req) in the cycle after ack; a req still high in the next IDLE is treated as a new request.
- Worst-case core wait with ext idle: (N_CORES-1)*3 cycles before its grant cycle.
- ext_req held continuously starves cores by design.

## Test plan
- Single write then read: core 2 writes 0xBEEF to 0x05 (ack[2] at T+1), then reads 0x05 -> ack[2] at T+2 with core_rdata=0xBEEF; mem_read_en high exactly one cycle.
- Round-robin: all four cores request reads continuously from reset -> grant order 0,1,2,3,0,1; each ack 3 cycles apart; never two acks in one cycle.
- Ext priority: ext write 0x1234 to 0x1FF while cores 0,1 request -> ext served first, ext_ack at T+1; next grant is core 0 (ptr unchanged).
- Fairness after skip: only cores 1 and 3 request with ptr=1 -> core 3 then core 1; ptr ends at 1.
- Dropped request: core 0 deasserts req in ACCESS of its write to 0x10 -> memory still written, ack[0] pulses once, no repeat grant.
- Reset mid-read: reset_n low during ACCESS of a read -> no RDATA ack afterward; all outputs zero next cycle; first grant after release goes to core 0.
